// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, read FSM encoding and bit-reversal helper for the FFT output reorder buffer
// Purpose: common definitions imported by fft_output_reorder.
//   MAX_LOG2_POINTS : largest supported log2 of the FFT length
//   ST_IDLE/ST_READ : read-side FSM encoding (rd_state_t)
//   fft_points()    : N = 2**log2_points
//   bitrev()        : reverse the low 'width' bits of a value
package fft_pkg;

  localparam int MAX_LOG2_POINTS = 10;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t ST_IDLE = 1'b0;
  localparam rd_state_t ST_READ = 1'b1;

  function automatic int fft_points(input int log2_points);
    return 1 << log2_points;
  endfunction

  // Bits at or above 'width' come back as zero.
  function automatic logic [MAX_LOG2_POINTS-1:0] bitrev(
    input logic [MAX_LOG2_POINTS-1:0] value,
    input int                         width
  );
    logic [MAX_LOG2_POINTS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2_POINTS; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// rtl/fft_reorder_ram.sv - simple dual-port RAM with one write port and one registered read port
// Purpose: sample storage for both ping-pong banks.
//   clock, resetn : clock and async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i  : read request; rdata_o is valid the cycle after re_i
module fft_reorder_ram #(
  parameter int addr_width = 7,
  parameter int word_width = 26
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [word_width-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [word_width-1:0] rdata_o
);

  // The array has no reset so it maps onto block RAM.
  logic [word_width-1:0] mem_q [0:(1<<addr_width)-1];
  logic [word_width-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset, so the outputs read zero straight out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_output_reorder.sv
// rtl/fft_output_reorder.sv - ping-pong bit-reversal reorder buffer emitting FFT bins in natural order
// Purpose: frames arrive in bit-reversed bin order and leave in natural order.
//   clock, resetn       : clock, async active-low reset
//   din_r/din_i         : input sample, din_valid qualifies, din_sof marks the first sample of a frame
//   dout_r/dout_i       : output sample, with dout_valid, dout_sof (bin 0) and dout_index (bin number)
//   overflow            : sticky, set when a frame was dropped because no bank was free
//   test_stall_read     : holds the reader in IDLE; used only to exercise the overflow path
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int data_width      = 13,
  parameter int log2_points     = 6,
  parameter bit test_stall_read = 1'b0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [data_width-1:0]  din_r,
  input  logic [data_width-1:0]  din_i,
  input  logic                   din_valid,
  input  logic                   din_sof,
  output logic [data_width-1:0]  dout_r,
  output logic [data_width-1:0]  dout_i,
  output logic                   dout_valid,
  output logic                   dout_sof,
  output logic [log2_points-1:0] dout_index,
  output logic                   overflow
);

  localparam int N = fft_points(log2_points);
  localparam int AW = log2_points + 1;

  logic [log2_points-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, widx, wrev;
  logic                   wbank_q, wbank_d, rbank_q, rbank_d;
  logic                   drop_q, drop_d, ovf_q, ovf_d;
  logic [1:0]             full_q, full_d, wr_set, rd_clear;
  rd_state_t              state_q, state_d;
  logic                   frame_start, bank_free, rd_issue, rd_done, we;
  logic                   vld_q, sof_q;
  logic [log2_points-1:0] idx_q;
  logic [2*data_width-1:0] rdata;

  always_comb begin
    // A din_sof restarts the frame at index 0 in the current bank.
    widx        = din_sof ? '0 : wcnt_q;
    wrev        = log2_points'(bitrev(MAX_LOG2_POINTS'(widx), log2_points));
    frame_start = din_valid && (widx == '0);
    rd_issue    = (state_q == ST_READ);
    rd_done     = rd_issue && (rcnt_q == '1);
    rd_clear    = rd_done ? (2'b01 << rbank_q) : 2'b00;
    // A bank whose last bin is being read this cycle is free for the next frame's
    // first sample: that sample lands at address 0, never at the bin still being read.
    bank_free   = !full_q[wbank_q] || rd_clear[wbank_q];

    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    wr_set  = 2'b00;
    we      = 1'b0;
    if (din_valid && !(drop_q && !din_sof)) begin
      if (frame_start && !bank_free) begin
        ovf_d  = 1'b1;
        drop_d = 1'b1;
        wcnt_d = '0;
      end else begin
        we     = 1'b1;
        drop_d = 1'b0;
        if (widx == '1) begin
          wr_set  = 2'b01 << wbank_q;
          wbank_d = ~wbank_q;
          wcnt_d  = '0;
        end else begin
          wcnt_d = widx + 1'b1;
        end
      end
    end
    full_d = (full_q & ~rd_clear) | wr_set;

    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rbank_q] && !test_stall_read) begin
          state_d = ST_READ;
          rcnt_d  = '0;
        end
      end
      ST_READ: begin
        if (rd_done) begin
          rbank_d = ~rbank_q;
          rcnt_d  = '0;
          if (!full_q[~rbank_q]) state_d = ST_IDLE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 2'b00;
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
      // Read-issue flags delayed one cycle to line up with the registered RAM output.
      vld_q   <= rd_issue;
      sof_q   <= rd_issue && (rcnt_q == '0);
      idx_q   <= rd_issue ? rcnt_q : '0;
    end
  end

  fft_reorder_ram #(
    .addr_width (AW),
    .word_width (2*data_width)
  ) u_ram (
    .clock   (clock),
    .resetn  (resetn),
    .we_i    (we),
    .waddr_i ({wbank_q, wrev}),
    .wdata_i ({din_r, din_i}),
    .re_i    (rd_issue),
    .raddr_i ({rbank_q, rcnt_q}),
    .rdata_o (rdata)
  );

  assign dout_r     = rdata[2*data_width-1:data_width];
  assign dout_i     = rdata[data_width-1:0];
  assign dout_valid = vld_q;
  assign dout_sof   = sof_q;
  assign dout_index = idx_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// tb/tb_fft_output_reorder.sv - self-checking bench for fft_output_reorder against a frame-level reference model
module tb_fft_output_reorder;

  localparam int DW = 13;
  localparam int L2 = 3;
  localparam int N  = 1 << L2;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          resetn2 = 1'b0;
  logic [DW-1:0] din_r = '0, din_i = '0;
  logic          din_valid = 1'b0, din_sof = 1'b0;
  logic          din_valid2 = 1'b0, din_sof2 = 1'b0;
  logic [DW-1:0] dout_r, dout_i, dout_r2, dout_i2;
  logic          dout_valid, dout_sof, overflow;
  logic          dout_valid2, dout_sof2, overflow2;
  logic [L2-1:0] dout_index;
  logic [1:0]    dout_index2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [2*DW-1:0] d;
    int              idx;
    int              at;
  } exp_t;

  exp_t            expq[$];
  logic [2*DW-1:0] partial[$];
  int              prev_start = -1000;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fft_output_reorder #(.data_width(DW), .log2_points(L2)) dut (
    .clock(clock), .resetn(resetn), .din_r(din_r), .din_i(din_i),
    .din_valid(din_valid), .din_sof(din_sof), .dout_r(dout_r), .dout_i(dout_i),
    .dout_valid(dout_valid), .dout_sof(dout_sof), .dout_index(dout_index),
    .overflow(overflow)
  );

  fft_output_reorder #(.data_width(DW), .log2_points(2), .test_stall_read(1'b1)) dut_ovf (
    .clock(clock), .resetn(resetn2), .din_r(din_r), .din_i(din_i),
    .din_valid(din_valid2), .din_sof(din_sof2), .dout_r(dout_r2), .dout_i(dout_i2),
    .dout_valid(dout_valid2), .dout_sof(dout_sof2), .dout_index(dout_index2),
    .overflow(overflow2)
  );

  function automatic int rev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if ((v >> i) & 1) r |= 1 << (w - 1 - i);
    return r;
  endfunction

  // Reference: a frame is N consecutive accepted samples (sof restarts it);
  // input position p carries bin rev(p). Bin 0 leaves two edges after the last
  // sample, or right after the previous frame if the reader is still busy.
  task automatic model_accept(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic sof);
    logic [2*DW-1:0] arr [N];
    int start;
    if (sof) partial.delete();
    partial.push_back({r, i});
    if (partial.size() == N) begin
      for (int p = 0; p < N; p++) arr[rev(p, L2)] = partial[p];
      start = (cyc + 2 > prev_start + N) ? cyc + 2 : prev_start + N;
      for (int j = 0; j < N; j++) expq.push_back('{d: arr[j], idx: j, at: start + j});
      prev_start = start;
      partial.delete();
    end
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic sof);
    din_r = r; din_i = i; din_valid = 1'b1; din_sof = sof;
    @(posedge clock); #1;
    model_accept(r, i, sof);
    din_valid = 1'b0; din_sof = 1'b0;
  endtask

  task automatic send2(input logic sof);
    din_r = DW'($urandom); din_i = DW'($urandom); din_valid2 = 1'b1; din_sof2 = sof;
    @(posedge clock); #1;
    din_valid2 = 1'b0; din_sof2 = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; din_sof = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 300 && expq.size() != 0; t++) @(negedge clock);
    checks++;
    assert (expq.size() == 0) else begin
      failures++; $error("FAIL %s_drain pending=%0d expected=0", tag, expq.size());
    end
  endtask

  // Output monitor: every valid output must be the next expected bin at its expected cycle.
  always @(negedge clock) begin
    exp_t e;
    if (resetn) begin
      if (dout_valid) begin
        checks++;
        assert (expq.size() > 0) else begin
          failures++; $error("FAIL unexpected_out idx=%0d got=%h expected=none", dout_index, {dout_r, dout_i});
        end
        if (expq.size() > 0) begin
          e = expq.pop_front();
          checks++;
          assert ({dout_r, dout_i} === e.d) else begin
            failures++; $error("FAIL out_data bin=%0d got=%h expected=%h", e.idx, {dout_r, dout_i}, e.d);
          end
          checks++;
          assert (int'(dout_index) == e.idx) else begin
            failures++; $error("FAIL out_index got=%0d expected=%0d", dout_index, e.idx);
          end
          checks++;
          assert (dout_sof === (e.idx == 0)) else begin
            failures++; $error("FAIL out_sof bin=%0d got=%b expected=%b", e.idx, dout_sof, e.idx == 0);
          end
          checks++;
          assert (cyc == e.at) else begin
            failures++; $error("FAIL out_timing bin=%0d got_cycle=%0d expected_cycle=%0d", e.idx, cyc, e.at);
          end
        end
      end else begin
        checks++;
        assert (dout_sof === 1'b0) else begin
          failures++; $error("FAIL sof_without_valid got=%b expected=0", dout_sof);
        end
        checks++;
        assert (!(expq.size() > 0 && expq[0].at <= cyc)) else begin
          failures++; $error("FAIL missing_out bin=%0d got_valid=0 expected_valid=1", expq[0].idx);
          void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    logic found;
    // Reset state
    repeat (3) begin @(posedge clock); #1; end
    checks++;
    assert ({dout_r, dout_i, dout_valid, dout_sof, dout_index, overflow} === '0) else begin
      failures++; $error("FAIL reset_outputs got=%h expected=0", {dout_r, dout_i, dout_valid, dout_sof, dout_index, overflow});
    end
    resetn = 1'b1; resetn2 = 1'b1;
    idle(2);

    // Single frame: input is bitrev(k), so output bin j must carry j
    for (int k = 0; k < N; k++) send(DW'(rev(k, L2)), DW'(rev(k, L2)), k == 0);
    idle(14);
    drain("single");

    // Four back-to-back frames, din_valid held high
    din_valid = 1'b1;
    for (int k = 0; k < 4 * N; k++) send(DW'($urandom), DW'($urandom), k == 0);
    idle(2);
    drain("burst");

    // Gapped input, one valid every third cycle
    for (int k = 0; k < 2 * N; k++) begin
      send(DW'($urandom), DW'($urandom), (k % N) == 0);
      idle(2);
    end
    drain("gapped");

    // sof reasserted at sample 5 discards the partial frame
    for (int k = 0; k < 5; k++) send(DW'($urandom), DW'($urandom), k == 0);
    for (int k = 0; k < N; k++) send(DW'($urandom), DW'($urandom), k == 0);
    idle(16);
    drain("resync");

    // Randomly gapped frames
    for (int k = 0; k < 3 * N; k++) begin
      send(DW'($urandom), DW'($urandom), k == 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    drain("random");
    checks++;
    assert (overflow === 1'b0) else begin
      failures++; $error("FAIL no_overflow got=%b expected=0", overflow);
    end

    // Reset while bin 3 is on the output
    for (int k = 0; k < N; k++) send(DW'($urandom), DW'($urandom), k == 0);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clock);
      found = dout_valid && (dout_index == 3);
    end
    checks++;
    assert (found) else begin
      failures++; $error("FAIL reach_bin3 got=0 expected=1");
    end
    #1 resetn = 1'b0;
    expq.delete(); partial.delete(); prev_start = -1000;
    #1;
    checks++;
    assert ({dout_r, dout_i, dout_valid, dout_sof, dout_index} === '0) else begin
      failures++; $error("FAIL async_reset got=%h expected=0", {dout_r, dout_i, dout_valid, dout_sof, dout_index});
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    idle(3);
    for (int k = 0; k < 3; k++) send(DW'($urandom), DW'($urandom), k == 0);
    idle(20);
    for (int k = 0; k < N; k++) send(DW'($urandom), DW'($urandom), k == 0);
    idle(12);
    drain("post_reset");

    // Overflow: stalled reader with N=4, third frame has no free bank
    for (int k = 0; k < 8; k++) send2(k % 4 == 0);
    checks++;
    assert (overflow2 === 1'b0) else begin
      failures++; $error("FAIL ovf_two_frames got=%b expected=0", overflow2);
    end
    send2(1'b1);
    checks++;
    assert (overflow2 === 1'b1) else begin
      failures++; $error("FAIL ovf_third_frame got=%b expected=1", overflow2);
    end
    for (int k = 0; k < 7; k++) send2(k % 4 == 3);
    repeat (10) begin @(posedge clock); #1; end
    checks++;
    assert (overflow2 === 1'b1 && dout_valid2 === 1'b0) else begin
      failures++; $error("FAIL ovf_sticky got=%b%b expected=10", overflow2, dout_valid2);
    end
    resetn2 = 1'b0; #1;
    checks++;
    assert (overflow2 === 1'b0) else begin
      failures++; $error("FAIL ovf_reset got=%b expected=0", overflow2);
    end
    resetn2 = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
